// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU/RAM command sequencer: default widths, the
// eight ALU operation codes, and the sequencer state encoding.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 6;

    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_XOR = 3'b010;
    localparam logic [2:0] ALU_OP_NOR = 3'b011;
    localparam logic [2:0] ALU_OP_ADD = 3'b100;
    localparam logic [2:0] ALU_OP_SUB = 3'b101;
    localparam logic [2:0] ALU_OP_SLT = 3'b110;
    localparam logic [2:0] ALU_OP_SHL = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RDA  = 3'd1,
        ST_RDB  = 3'd2,
        ST_LATB = 3'd3,
        ST_EXE  = 3'd4,
        ST_WB   = 3'd5
    } seq_state_t;

endpackage

// File: rtl/alu_ram_sequencer.sv
// -----------------------------------------------------------------------------
// alu_ram_sequencer
// Runs one ALU operation per command against a synchronous-read RAM:
// read A, read B, execute, write the result back, report result and flags.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op/ra/rb/rd          operation, operand A/B addresses, destination
//   mem_addr/we/wdata/rdata  RAM port (rdata valid one cycle after addr)
//   alu_a/alu_b/alu_op       ALU operands, always driven from the latched values
//   alu_f/alu_zf/alu_of      combinational ALU result and flags
//   done                     one-cycle completion pulse (during write-back)
//   res_f/res_zf/res_of      last result and flags, held until next completion
//   dbg_state                current FSM state
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both 1. cmd_ready is 1 only in IDLE; cmd_valid in any other
// state is ignored (no queueing), and the producer must hold the command
// stable until it transfers.
// -----------------------------------------------------------------------------
module alu_ram_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_ra,
    input  logic [ADDR_W-1:0] cmd_rb,
    input  logic [ADDR_W-1:0] cmd_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_f,
    input  logic              alu_zf,
    input  logic              alu_of,
    output logic              done,
    output logic [DATA_W-1:0] res_f,
    output logic              res_zf,
    output logic              res_of,
    output logic [2:0]        dbg_state
);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_ra;
    logic [ADDR_W-1:0] r_rb;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [DATA_W-1:0] r_res_f;
    logic              r_res_zf;
    logic              r_res_of;
    logic              w_is_arith;

    // Overflow only has meaning for ADD/SUB; other ops report 0.
    assign w_is_arith = (r_op == ALU_OP_ADD) || (r_op == ALU_OP_SUB);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath registers. Read data lags the address by one cycle, so
    // operand A (addressed in RDA) is captured in RDB and operand B
    // (addressed in RDB) is captured in LATB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_rd     <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_res_f  <= '0;
            r_res_zf <= 1'b0;
            r_res_of <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op <= cmd_op;
                        r_ra <= cmd_ra;
                        r_rb <= cmd_rb;
                        r_rd <= cmd_rd;
                    end
                end
                ST_RDB:  r_opa <= mem_rdata;
                ST_LATB: r_opb <= mem_rdata;
                ST_EXE: begin
                    r_res_f  <= alu_f;
                    r_res_zf <= alu_zf;
                    r_res_of <= w_is_arith ? alu_of : 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        mem_addr     = '0;
        mem_we       = 1'b0;
        mem_wdata    = '0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next_state = ST_RDA;
                end
            end
            ST_RDA: begin
                mem_addr     = r_ra;
                w_next_state = ST_RDB;
            end
            ST_RDB: begin
                mem_addr     = r_rb;
                w_next_state = ST_LATB;
            end
            ST_LATB: w_next_state = ST_EXE;
            ST_EXE:  w_next_state = ST_WB;
            ST_WB: begin
                mem_addr     = r_rd;
                mem_we       = 1'b1;
                mem_wdata    = r_res_f;
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign alu_a     = r_opa;
    assign alu_b     = r_opb;
    assign alu_op    = r_op;
    assign res_f     = r_res_f;
    assign res_zf    = r_res_zf;
    assign res_of    = r_res_of;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_ram_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_ram_sequencer
// Bench for alu_ram_sequencer. Provides a synchronous-read 64-word RAM and a
// combinational ALU around the DUT, a transaction-level reference model, a
// per-cycle compare process, and directed commands with literal expectations.
// -----------------------------------------------------------------------------
module tb_alu_ram_sequencer;
    import alu_seq_pkg::*;

    localparam int DW = 32;
    localparam int AW = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [AW-1:0] cmd_ra, cmd_rb, cmd_rd;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] alu_a, alu_b, alu_f;
    logic [2:0]    alu_op;
    logic          alu_zf, alu_of;
    logic          done;
    logic [DW-1:0] res_f;
    logic          res_zf, res_of;
    logic [2:0]    dbg_state;

    alu_ram_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_rd    (cmd_rd),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_f     (alu_f),
        .alu_zf    (alu_zf),
        .alu_of    (alu_of),
        .done      (done),
        .res_f     (res_f),
        .res_zf    (res_zf),
        .res_of    (res_of),
        .dbg_state (dbg_state)
    );

    // ---------------- environment: RAM with a preload path ----------------
    logic [DW-1:0] ram [64];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) ram[ld_addr] <= ld_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // ---------------- environment: ALU ----------------
    // Reports a junk overflow of 1 on non-arithmetic ops so the sequencer's
    // masking of that flag is visible.
    always_comb begin
        alu_f  = '0;
        alu_of = 1'b1;
        case (alu_op)
            3'b000: alu_f = alu_a & alu_b;
            3'b001: alu_f = alu_a | alu_b;
            3'b010: alu_f = alu_a ^ alu_b;
            3'b011: alu_f = ~(alu_a | alu_b);
            3'b100: begin
                alu_f  = alu_a + alu_b;
                alu_of = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'b101: begin
                alu_f  = alu_a - alu_b;
                alu_of = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
            end
            3'b110: alu_f = (alu_a < alu_b) ? 32'd1 : 32'd0;
            default: alu_f = alu_b << alu_a[4:0];
        endcase
    end
    assign alu_zf = (alu_f == '0);

    // ---------------- reference model ----------------
    // Returns {zf, of, f} from signed/unsigned integer arithmetic.
    function automatic logic [DW+1:0] model_op(input logic [2:0] op,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        longint sa, sb, s;
        logic [DW-1:0] f;
        logic of;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        of = 1'b0;
        f  = '0;
        case (op)
            ALU_OP_AND: f = a & b;
            ALU_OP_OR:  f = a | b;
            ALU_OP_XOR: f = a ^ b;
            ALU_OP_NOR: f = ~(a | b);
            ALU_OP_ADD: begin
                s  = sa + sb;
                f  = s[DW-1:0];
                of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_OP_SUB: begin
                s  = sa - sb;
                f  = s[DW-1:0];
                of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            ALU_OP_SLT: f = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            default:    f = b << a[4:0];
        endcase
        return {(f == '0), of, f};
    endfunction

    logic [DW-1:0] ref_mem [64];
    int            phase = 0;   // 0 idle, 1..5 = cycles since acceptance
    logic [2:0]    m_op;
    logic [AW-1:0] m_ra, m_rb, m_rd;
    logic [DW-1:0] m_a, m_b, m_f;
    logic          m_zf, m_of;
    logic [DW-1:0] h_f = '0;
    logic          h_zf = 1'b0, h_of = 1'b0;
    logic [DW-1:0] exp_q[$];

    always @(posedge clk) begin
        logic [DW+1:0] r;
        if (ld_en) ref_mem[ld_addr] <= ld_data;
        if (rst) begin
            phase <= 0;
            h_f   <= '0;
            h_zf  <= 1'b0;
            h_of  <= 1'b0;
            exp_q.delete();
        end else begin
            case (phase)
                0: if (cmd_valid) begin
                    r = model_op(cmd_op, ref_mem[cmd_ra], ref_mem[cmd_rb]);
                    m_op  <= cmd_op;
                    m_ra  <= cmd_ra;
                    m_rb  <= cmd_rb;
                    m_rd  <= cmd_rd;
                    m_a   <= ref_mem[cmd_ra];
                    m_b   <= ref_mem[cmd_rb];
                    m_f   <= r[DW-1:0];
                    m_zf  <= r[DW+1];
                    m_of  <= r[DW];
                    exp_q.push_back(r[DW-1:0]);
                    phase <= 1;
                end
                4: begin
                    h_f   <= m_f;
                    h_zf  <= m_zf;
                    h_of  <= m_of;
                    phase <= 5;
                end
                5: begin
                    ref_mem[m_rd] <= m_f;
                    phase <= 0;
                end
                default: phase <= phase + 1;
            endcase
        end
    end

    // ---------------- scoreboard / compare ----------------
    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int n_we     = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (chk_en) begin
            check("cmd_ready", {31'd0, cmd_ready}, {31'd0, phase == 0});
            check("done",      {31'd0, done},      {31'd0, phase == 5});
            check("mem_we",    {31'd0, mem_we},    {31'd0, phase == 5});
            check("res_f",     res_f,              h_f);
            check("res_zf",    {31'd0, res_zf},    {31'd0, h_zf});
            check("res_of",    {31'd0, res_of},    {31'd0, h_of});
            case (phase)
                0: check("mem_addr_idle", {26'd0, mem_addr}, 32'd0);
                1: check("mem_addr_ra",   {26'd0, mem_addr}, {26'd0, m_ra});
                2: check("mem_addr_rb",   {26'd0, mem_addr}, {26'd0, m_rb});
                4: begin
                    check("alu_a",  alu_a, m_a);
                    check("alu_b",  alu_b, m_b);
                    check("alu_op", {29'd0, alu_op}, {29'd0, m_op});
                end
                5: begin
                    check("mem_addr_rd", {26'd0, mem_addr}, {26'd0, m_rd});
                    check("mem_wdata",   mem_wdata, m_f);
                end
                default: ;
            endcase
            if (done) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("done_without_command");
                end else begin
                    e = exp_q.pop_front();
                    check("done_result", res_f, e);
                end
            end
        end
        if (done) n_done++;
        if (mem_we) n_we++;
    end

    // ---------------- driver tasks ----------------
    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(posedge clk); #1;
        ld_en   = 1'b0;
    endtask

    // Presents a command and returns #1 after the edge on which it transferred.
    task automatic send(input logic [2:0] op, input logic [AW-1:0] ra,
                        input logic [AW-1:0] rb, input logic [AW-1:0] rd,
                        input bit hold);
        bit ok;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rd    = rd;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("accept");
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("done");
    endtask

    task automatic run_cmd(input string name, input logic [2:0] op,
                           input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                           input logic [AW-1:0] rd, input logic [DW-1:0] ef,
                           input logic ezf, input logic eof);
        int lat;
        send(op, ra, rb, rd, 1'b0);
        wait_done(lat);
        check({name, "_latency"}, lat, 32'd5);
        check({name, "_res_f"}, res_f, ef);
        check({name, "_res_zf"}, {31'd0, res_zf}, {31'd0, ezf});
        check({name, "_res_of"}, {31'd0, res_of}, {31'd0, eof});
        @(posedge clk); #1;
        check({name, "_ram_rd"}, ram[rd], ef);
    endtask

    // ---------------- directed stimulus ----------------
    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] ra, rb, rd;
        logic [DW-1:0] f;
        logic          zf, of;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int t1, t2, d0, w0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_ra    = '0;
        cmd_rb    = '0;
        cmd_rd    = '0;

        vecs[0] = '{ALU_OP_XOR, 6'd1,  6'd2,  6'd20, 32'h7FFFFFFE, 1'b0, 1'b0};
        vecs[1] = '{ALU_OP_NOR, 6'd1,  6'd2,  6'd21, 32'h80000000, 1'b0, 1'b0};
        vecs[2] = '{ALU_OP_SLT, 6'd2,  6'd1,  6'd22, 32'h00000001, 1'b0, 1'b0};
        vecs[3] = '{ALU_OP_SLT, 6'd1,  6'd2,  6'd23, 32'h00000000, 1'b1, 1'b0};
        vecs[4] = '{ALU_OP_SUB, 6'd3,  6'd2,  6'd24, 32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[5] = '{ALU_OP_ADD, 6'd25, 6'd25, 6'd25, 32'h0000000A, 1'b0, 1'b0};

        // Reset held throughout the preload (well over two cycles).
        rst = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        load(6'd1,  32'h7FFFFFFF);
        load(6'd2,  32'h00000001);
        load(6'd3,  32'h00000000);
        load(6'd4,  32'h12345678);
        load(6'd5,  32'h12345678);
        load(6'd6,  32'hFFFFFFFF);
        load(6'd7,  32'h00000004);
        load(6'd8,  32'h00000001);
        load(6'd9,  32'hDEADBEEF);
        load(6'd11, 32'hAAAAAAAA);
        load(6'd12, 32'hAAAAAAAA);
        load(6'd25, 32'h00000005);
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_mem_we",    {31'd0, mem_we},    32'd0);
        check("rst_res_f",     res_f,              32'd0);
        check("rst_res_zf",    {31'd0, res_zf},    32'd0);
        check("rst_res_of",    {31'd0, res_of},    32'd0);
        @(posedge clk); #1;

        run_cmd("add_ovf", ALU_OP_ADD, 6'd1, 6'd2, 6'd3, 32'h80000000, 1'b0, 1'b1);
        run_cmd("sub_zero", ALU_OP_SUB, 6'd4, 6'd5, 6'd6, 32'h00000000, 1'b1, 1'b0);
        run_cmd("shl_rd_ra", ALU_OP_SHL, 6'd7, 6'd8, 6'd7, 32'h00000010, 1'b0, 1'b0);

        foreach (vecs[i])
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].ra, vecs[i].rb,
                    vecs[i].rd, vecs[i].f, vecs[i].zf, vecs[i].of);

        // Busy: valid held high across two back-to-back commands
        d0 = n_done;
        send(ALU_OP_OR, 6'd1, 6'd2, 6'd11, 1'b1);
        t1 = cyc;
        send(ALU_OP_AND, 6'd3, 6'd7, 6'd12, 1'b0);
        t2 = cyc;
        check("busy_accept_gap", t2 - t1, 32'd6);
        repeat (7) @(posedge clk);
        #1;
        check("busy_done_count", n_done - d0, 32'd2);
        check("busy_ram11", ram[11], 32'h7FFFFFFF);
        check("busy_ram12", ram[12], 32'h00000000);

        // Reset during EXE aborts the command
        d0 = n_done;
        w0 = n_we;
        send(ALU_OP_ADD, 6'd1, 6'd2, 6'd9, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (8) @(posedge clk);
        #1;
        check("abort_done_count", n_done - d0, 32'd0);
        check("abort_we_count", n_we - w0, 32'd0);
        check("abort_ram9", ram[9], 32'hDEADBEEF);
        check("abort_res_f", res_f, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
